// File: rtl/race_game_ctrl.sv
// Race game controller: lives/laps/countdown FSM driving status screens, pause and graphics reset.
// Optional RACE_TIMER_EN macro adds a saturating RUN-frame counter on race_time.
module race_game_ctrl #(
  parameter int unsigned NUM_LIVES    = 3,
  parameter int unsigned NUM_LAPS     = 3,
  parameter int unsigned COUNT_FRAMES = 180,
  parameter int unsigned CRASH_FRAMES = 120,
  parameter int unsigned LIFE_W       = 2,
  parameter int unsigned LAP_W        = 2,
  parameter int unsigned TIME_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              video_on,
  input  logic              road_on,
  input  logic              finish_line,
  input  logic              car_on,
  input  logic              enter_key,
  input  logic              key_release,
  output logic              start_en,
  output logic              crash_en,
  output logic              finish_en,
  output logic              over_en,
  output logic              countdown_on,
  output logic              pause,
  output logic              game_reset,
  output logic [LIFE_W-1:0] lives,
  output logic [LAP_W-1:0]  lap,
  output logic [TIME_W-1:0] race_time
);

  localparam int unsigned MAX_FRAMES = (COUNT_FRAMES > CRASH_FRAMES) ? COUNT_FRAMES : CRASH_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNTDOWN, S_RUN, S_PAUSED, S_CRASH, S_FINISH, S_OVER
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic [LAP_W-1:0]    lap_q, lap_d;
  logic                enter_q;
  logic                crash_hit_q, crash_hit_d;
  logic                fin_hit_q, fin_hit_d;
  logic                armed_q, armed_d;
  logic                game_reset_q, game_reset_d;
  logic                start_en_q, crash_en_q, finish_en_q, over_en_q, countdown_q, pause_q;

  logic enter_p, crash_px, fin_px, crash_now, fin_now;

  assign enter_p   = enter_key & ~enter_q & ~key_release;
  assign crash_px  = video_on & car_on & ~road_on & ~finish_line;
  assign fin_px    = video_on & car_on & finish_line;
  assign crash_now = crash_hit_q | crash_px;
  assign fin_now   = fin_hit_q | fin_px;

  // Next-state, counters and accumulators
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lives_d      = lives_q;
    lap_d        = lap_q;
    armed_d      = armed_q;
    game_reset_d = 1'b0;
    crash_hit_d  = crash_now;
    fin_hit_d    = fin_now;
    if (frame_tick) begin
      crash_hit_d = 1'b0;
      fin_hit_d   = 1'b0;
      if (!fin_now) armed_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (enter_p) begin
          state_d      = S_COUNTDOWN;
          lives_d      = LIFE_W'(NUM_LIVES);
          lap_d        = '0;
          cnt_d        = '0;
          game_reset_d = 1'b1;
          crash_hit_d  = 1'b0;
          fin_hit_d    = 1'b0;
          armed_d      = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(COUNT_FRAMES - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (frame_tick) begin
          if (crash_now) begin
            state_d = S_CRASH;
            cnt_d   = '0;
            if (lives_q != '0) lives_d = lives_q - LIFE_W'(1);
          end else if (fin_now && armed_q) begin
            armed_d = 1'b0;
            if (lap_q != LAP_W'(NUM_LAPS)) lap_d = lap_q + LAP_W'(1);
            if (lap_d == LAP_W'(NUM_LAPS)) state_d = S_FINISH;
          end
        end
        // The frame result wins over a coincident pause request
        if (enter_p && state_d == S_RUN) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        crash_hit_d = 1'b0;
        fin_hit_d   = 1'b0;
        if (enter_p) state_d = S_RUN;
      end
      S_CRASH: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(CRASH_FRAMES - 1)) begin
            cnt_d = '0;
            if (lives_q == '0) begin
              state_d = S_OVER;
            end else begin
              state_d      = S_COUNTDOWN;
              game_reset_d = 1'b1;
              crash_hit_d  = 1'b0;
              fin_hit_d    = 1'b0;
              armed_d      = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FINISH, S_OVER: begin
        if (enter_p) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lives_q      <= '0;
      lap_q        <= '0;
      enter_q      <= 1'b0;
      crash_hit_q  <= 1'b0;
      fin_hit_q    <= 1'b0;
      armed_q      <= 1'b0;
      game_reset_q <= 1'b1;
      start_en_q   <= 1'b1;
      crash_en_q   <= 1'b0;
      finish_en_q  <= 1'b0;
      over_en_q    <= 1'b0;
      countdown_q  <= 1'b0;
      pause_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      lap_q        <= lap_d;
      enter_q      <= enter_key;
      crash_hit_q  <= crash_hit_d;
      fin_hit_q    <= fin_hit_d;
      armed_q      <= armed_d;
      game_reset_q <= game_reset_d;
      start_en_q   <= (state_d == S_IDLE);
      crash_en_q   <= (state_d == S_CRASH);
      finish_en_q  <= (state_d == S_FINISH);
      over_en_q    <= (state_d == S_OVER);
      countdown_q  <= (state_d == S_COUNTDOWN);
      pause_q      <= (state_d != S_RUN);
    end
  end

  assign start_en     = start_en_q;
  assign crash_en     = crash_en_q;
  assign finish_en    = finish_en_q;
  assign over_en      = over_en_q;
  assign countdown_on = countdown_q;
  assign pause        = pause_q;
  assign game_reset   = game_reset_q;
  assign lives        = lives_q;
  assign lap          = lap_q;

`ifdef RACE_TIMER_EN
  logic [TIME_W-1:0] time_q, time_d;

  // Counts RUN frames only, saturating; cleared when a new race starts
  always_comb begin
    time_d = time_q;
    if (state_q == S_IDLE && state_d == S_COUNTDOWN) begin
      time_d = '0;
    end else if (state_q == S_RUN && frame_tick && time_q != '1) begin
      time_d = time_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) time_q <= '0;
    else       time_q <= time_d;
  end

  assign race_time = time_q;
`else
  assign race_time = '0;
`endif

endmodule

// File: tb/tb_race_game_ctrl.sv
// Scoreboard bench for race_game_ctrl: directed stimulus queues expectations, a monitor checks them.
module tb_race_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0, video_on = 1'b0, road_on = 1'b0, finish_line = 1'b0;
  logic        car_on = 1'b0, enter_key = 1'b0, key_release = 1'b0;
  logic        start_en, crash_en, finish_en, over_en, countdown_on, pause, game_reset;
  logic [1:0]  lives, lap;
  logic [15:0] race_time;

  race_game_ctrl #(
    .NUM_LIVES(2), .NUM_LAPS(2), .COUNT_FRAMES(4), .CRASH_FRAMES(2),
    .LIFE_W(2), .LAP_W(2), .TIME_W(16)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .video_on(video_on),
    .road_on(road_on), .finish_line(finish_line), .car_on(car_on),
    .enter_key(enter_key), .key_release(key_release),
    .start_en(start_en), .crash_en(crash_en), .finish_en(finish_en), .over_en(over_en),
    .countdown_on(countdown_on), .pause(pause), .game_reset(game_reset),
    .lives(lives), .lap(lap), .race_time(race_time)
  );

  always #5 clk = ~clk;

`ifdef RACE_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  localparam logic [15:0] RT10 = TIMER_EN ? 16'd10 : 16'd0;

  // Flag order: {start, crash, finish, over, countdown, pause, game_reset}
  localparam logic [6:0] IDLE_RST = 7'b1000011;
  localparam logic [6:0] IDLE_F   = 7'b1000010;
  localparam logic [6:0] CD_RST   = 7'b0000111;
  localparam logic [6:0] CD_F     = 7'b0000110;
  localparam logic [6:0] RUN_F    = 7'b0000000;
  localparam logic [6:0] PAUSED_F = 7'b0000010;
  localparam logic [6:0] CRASH_F  = 7'b0100010;
  localparam logic [6:0] FIN_F    = 7'b0010010;
  localparam logic [6:0] OVER_F   = 7'b0001010;

  typedef struct {
    int          cyc;
    string       name;
    logic [6:0]  flags;
    logic [1:0]  lives;
    logic [1:0]  lap;
    logic [15:0] rt;
    bit          chk_rt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string name, input logic [6:0] f, input logic [1:0] lv,
                      input logic [1:0] lp, input logic [15:0] rt, input bit chk_rt);
    exp_t e;
    e.cyc = cyc; e.name = name; e.flags = f; e.lives = lv; e.lap = lp;
    e.rt = rt; e.chk_rt = chk_rt;
    sb_q.push_back(e);
  endtask

  // Timer value is only known exactly in the default build unless checked explicitly
  task automatic chk(input string name, input logic [6:0] f, input logic [1:0] lv, input logic [1:0] lp);
    push(name, f, lv, lp, 16'd0, !TIMER_EN);
  endtask

  task automatic chk_t(input string name, input logic [6:0] f, input logic [1:0] lv,
                       input logic [1:0] lp, input logic [15:0] rt);
    push(name, f, lv, lp, rt, 1'b1);
  endtask

  // Monitor: compares queued expectations against outputs just after each falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        exp_t e;
        logic [6:0] act;
        e = sb_q.pop_front();
        act = {start_en, crash_en, finish_en, over_en, countdown_on, pause, game_reset};
        n_tests++;
        if (e.cyc != cyc || act !== e.flags || lives !== e.lives || lap !== e.lap ||
            (e.chk_rt && race_time !== e.rt)) begin
          n_fail++;
          $display("FAIL %s: got flags=%b lives=%0d lap=%0d time=%0d, want flags=%b lives=%0d lap=%0d time=%0d (cyc %0d/%0d)",
                   e.name, act, lives, lap, race_time, e.flags, e.lives, e.lap, e.rt, cyc, e.cyc);
        end
      end
    end
  end

  task automatic cyc1();
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk); enter_key = 1'b1;
    @(negedge clk); enter_key = 1'b0;
  endtask

  task automatic pix(input bit cr);
    @(negedge clk);
    video_on = 1'b1; car_on = 1'b1;
    road_on = !cr; finish_line = !cr;
    @(negedge clk);
    video_on = 1'b0; car_on = 1'b0; road_on = 1'b0; finish_line = 1'b0;
  endtask

  task automatic frame(input bit cr, input bit fi);
    if (cr) pix(1'b1);
    if (fi) pix(1'b0);
    tick();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset and first race start
    repeat (2) cyc1();
    chk("rst_hold", IDLE_RST, 2'd0, 2'd0);
    n_tests++;
    if (start_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_start_en: got %b want 1", start_en);
    end
    n_tests++;
    if (pause !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pause: got %b want 1", pause);
    end
    n_tests++;
    if (game_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_game_reset: got %b want 1", game_reset);
    end
    reset = 1'b0;
    cyc1();
    chk("rst_release", IDLE_F, 2'd0, 2'd0);
    press();
    chk("enter_start", CD_RST, 2'd2, 2'd0);
    cyc1();
    chk("cd_pulse_end", CD_F, 2'd2, 2'd0);
    press();
    chk("cd_enter_ignored", CD_F, 2'd2, 2'd0);
    ticks(3);
    chk("cd_3_ticks", CD_F, 2'd2, 2'd0);
    tick();
    chk("run_entry", RUN_F, 2'd2, 2'd0);
    n_tests++;
    if (pause !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry_pause: got %b want 0", pause);
    end
    n_tests++;
    if (countdown_on !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry_countdown: got %b want 0", countdown_on);
    end

    // First crash, recovery via countdown
    frame(1'b1, 1'b0);
    chk("crash1", CRASH_F, 2'd1, 2'd0);
    tick();
    chk("crash_hold", CRASH_F, 2'd1, 2'd0);
    tick();
    chk("crash_to_cd", CD_RST, 2'd1, 2'd0);
    cyc1();
    chk("cd_after_crash", CD_F, 2'd1, 2'd0);
    ticks(4);
    chk("run2", RUN_F, 2'd1, 2'd0);

    // Second crash with pixel on the tick cycle, then game over
    @(negedge clk);
    video_on = 1'b1; car_on = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    video_on = 1'b0; car_on = 1'b0; frame_tick = 1'b0;
    chk("crash2_same_cycle", CRASH_F, 2'd0, 2'd0);
    ticks(2);
    chk("over", OVER_F, 2'd0, 2'd0);
    @(negedge clk); enter_key = 1'b1; key_release = 1'b1;
    @(negedge clk); enter_key = 1'b0; key_release = 1'b0;
    chk("over_break_ignored", OVER_F, 2'd0, 2'd0);
    press();
    chk("over_to_idle", IDLE_F, 2'd0, 2'd0);

    // Laps: straddling the line counts once, re-arm, then win
    press();
    chk("start2", CD_RST, 2'd2, 2'd0);
    ticks(4);
    frame(1'b0, 1'b1);
    chk("lap1", RUN_F, 2'd2, 2'd1);
    frame(1'b0, 1'b1);
    chk("straddle_a", RUN_F, 2'd2, 2'd1);
    frame(1'b0, 1'b1);
    chk("straddle_b", RUN_F, 2'd2, 2'd1);
    frame(1'b0, 1'b0);
    chk("rearm_frame", RUN_F, 2'd2, 2'd1);
    frame(1'b0, 1'b1);
    chk("finish", FIN_F, 2'd2, 2'd2);
    press();
    chk("finish_to_idle", IDLE_F, 2'd2, 2'd2);

    // Crash beats finish; pause behaviour; coincident tick and enter
    press();
    chk("start3", CD_RST, 2'd2, 2'd0);
    ticks(4);
    frame(1'b1, 1'b1);
    chk("crash_over_finish", CRASH_F, 2'd1, 2'd0);
    ticks(2);
    chk("crash_to_cd2", CD_RST, 2'd1, 2'd0);
    ticks(4);
    chk("run3", RUN_F, 2'd1, 2'd0);
    press();
    chk("pause_on", PAUSED_F, 2'd1, 2'd0);
    frame(1'b1, 1'b0);
    chk("paused_no_crash", PAUSED_F, 2'd1, 2'd0);
    pix(1'b1);
    press();
    chk("pause_off", RUN_F, 2'd1, 2'd0);
    tick();
    chk("acc_held_clear", RUN_F, 2'd1, 2'd0);
    @(negedge clk); enter_key = 1'b1; key_release = 1'b1;
    @(negedge clk);
    chk("break_no_pause", RUN_F, 2'd1, 2'd0);
    enter_key = 1'b0; key_release = 1'b0;
    pix(1'b1);
    @(negedge clk); frame_tick = 1'b1; enter_key = 1'b1;
    @(negedge clk); frame_tick = 1'b0; enter_key = 1'b0;
    chk("tick_enter_crash_first", CRASH_F, 2'd0, 2'd0);
    ticks(2);
    chk("over2", OVER_F, 2'd0, 2'd0);
    press();

    // Asynchronous reset mid-countdown
    press();
    chk("start4", CD_RST, 2'd2, 2'd0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid_cd", IDLE_RST, 2'd0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc1();
    chk("rst_mid_release", IDLE_F, 2'd0, 2'd0);

    // Race timer counts RUN frames and holds while paused
    press();
    ticks(4);
    chk_t("timer_run0", RUN_F, 2'd2, 2'd0, 16'd0);
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b0);
    chk_t("timer_10", RUN_F, 2'd2, 2'd0, RT10);
    press();
    ticks(2);
    chk_t("timer_hold_paused", PAUSED_F, 2'd2, 2'd0, RT10);

    repeat (3) @(negedge clk);
    #2;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation never checked (cyc %0d, now %0d)", e.name, e.cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/race_game_ctrl.md
Name: race_game_ctrl

Overview:
- Parametrised next-generation race game controller.
- Replaces the fixed start/crash/finish sequencer with a lives, laps and countdown game FSM.
- Sits between keyboard decode, graphics pixel flags and the vga_sync frame timing.
- Drives the status enables, pause (graphics and audio) and game_reset (graphics).

Parameters:
- NUM_LIVES, 3, lives granted at race start (1..2^LIFE_W-1).
- NUM_LAPS, 3, finish-line crossings to win (1..2^LAP_W-1).
- COUNT_FRAMES, 180, frames spent in pre-race countdown (>=1).
- CRASH_FRAMES, 120, frames the crash screen is held (>=1).
- LIFE_W, 2, width of lives output.
- LAP_W, 2, width of lap output.
- TIME_W, 16, width of race_time.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (end of active video).
- video_on  in  1  pixel in active area.
- road_on  in  1  current pixel is road.
- finish_line  in  1  current pixel is finish line.
- car_on  in  1  current pixel is car.
- enter_key  in  1  enter key level from keyboard.
- key_release  in  1  break code flag from keyboard.
- start_en  out  1  start screen active.
- crash_en  out  1  crash screen active.
- finish_en  out  1  win screen active.
- over_en  out  1  game-over screen active.
- countdown_on  out  1  countdown in progress.
- pause  out  1  motion/audio freeze.
- game_reset  out  1  graphics reposition/reset.
- lives  out  LIFE_W  remaining lives.
- lap  out  LAP_W  completed laps.
- race_time  out  TIME_W  RUN frame count.

Behaviour:
- Single clock domain. reset is asynchronous, active-high; all state clears immediately, including mid-race.
- Reset values:
  - state = IDLE, start_en = 1, pause = 1, game_reset = 1.
  - All other outputs 0; lives = 0, lap = 0.
- All outputs are registered.
- Enter press: enter_p = enter_key & ~enter_key_d & ~key_release (rising edge, one cycle).
- Pixel hit accumulators:
  - crash_hit is set by video_on & car_on & ~road_on & ~finish_line.
  - fin_hit is set by video_on & car_on & finish_line.
  - The value evaluated at frame_tick includes that cycle's pixel. Both accumulators clear in the same cycle.
- armed flag: cleared when a lap is counted; set at any frame_tick where fin_hit = 0. This prevents multi-counting while the car straddles the line.
- States:
  - IDLE: start_en = 1. On enter_p: lives <= NUM_LIVES, lap <= 0, race_time <= 0, frame counter <= 0, 1-cycle game_reset pulse, go to COUNTDOWN.
  - COUNTDOWN: countdown_on = 1. Counts frame_ticks; the COUNT_FRAMES-th tick moves to RUN. Accumulators and armed are cleared on entry. enter_p is ignored.
  - RUN: pause = 0. On frame_tick:
    - If crash_hit, go to CRASH and decrement lives. Crash has priority over finish in the same frame.
    - Else if fin_hit & armed, increment lap; if the new lap equals NUM_LAPS, go to FINISH.
    - enter_p goes to PAUSED. If enter_p and frame_tick coincide, the frame is evaluated first and the pause is taken only if the state is still RUN.
  - PAUSED: crash/finish evaluation is suspended and accumulators are held clear. enter_p returns to RUN.
  - CRASH: crash_en = 1, held for CRASH_FRAMES ticks. Then:
    - lives == 0 → OVER.
    - Otherwise → COUNTDOWN with a 1-cycle game_reset pulse; lap is retained.
  - FINISH: finish_en = 1. enter_p → IDLE.
  - OVER: over_en = 1. enter_p → IDLE.
- pause = 1 in every state except RUN.
- game_reset outside reset is exactly one cycle, registered alongside the state change.
- lives and lap never wrap: lives saturates at 0, and lap stops at NUM_LAPS.

Optional Feature:
- Macro: RACE_TIMER_EN.
- Defined: race_time increments once per frame_tick while in RUN only, saturates at 2^TIME_W-1, clears on IDLE→COUNTDOWN, and is held through CRASH, FINISH and OVER.
- Undefined: race_time is tied to 0 and no counter is synthesised.

Test Plan:
All scenarios use COUNT_FRAMES=4, CRASH_FRAMES=2, NUM_LIVES=2, NUM_LAPS=2.
- Reset then release → start_en=1, pause=1, game_reset=1 until the first clk after release, then 0. Enter press → one game_reset pulse, countdown_on=1, lives=2. 4 frame_ticks later: pause=0, countdown_on=0.
- In RUN, car_on & ~road_on for one pixel → at next frame_tick crash_en=1, lives=1. After 2 ticks: COUNTDOWN plus game_reset pulse.
- Second crash → lives=0, then after 2 ticks over_en=1. Enter press → start_en=1.
- Finish line touched across 3 consecutive frames → lap=1 only. Clear frame, then touch again → lap=2, finish_en=1, pause=1.
- Crash and finish pixels in the same frame → crash_en=1, lap unchanged. Enter press during RUN → pause=1. Second press → pause=0. Enter held with key_release=1 → no transition.
- Reset asserted mid-COUNTDOWN → immediate IDLE outputs. With RACE_TIMER_EN defined, 10 RUN frames → race_time=10, which holds during PAUSED.
